// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 8-bit LFSR byte stream (x^8+x^6+x^5+x^4+1).
// Build option: define PRBS_CHK_RESYNC_EN to drop lock after LOSS_CNT consecutive mismatches.
module prbs_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [7:0]       data,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);

    if (LOCK_CNT < 1 || LOCK_CNT > 15 || LOSS_CNT < 1 || LOSS_CNT > 15) begin : g_bad_param
        $error("prbs_checker: LOCK_CNT and LOSS_CNT must be in 1..15");
    end

    state_t     state, state_nxt;
    logic [7:0] pred, pred_nxt;
    logic [3:0] match_cnt, match_nxt;
    logic [3:0] miss_cnt, miss_nxt;
    logic       mismatch;

    function automatic logic [7:0] lfsr_f(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    always_comb begin
        state_nxt = state;
        pred_nxt  = pred;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        mismatch  = 1'b0;
        if (valid) begin
            case (state)
                HUNT: begin
                    // zero is the LFSR lockup value and can never seed a stream
                    if (data != 8'h00) begin
                        pred_nxt  = lfsr_f(data);
                        match_nxt = 4'd0;
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (data == pred) begin
                        pred_nxt  = lfsr_f(data);
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt == LOCK_LAST) begin
                            state_nxt = LOCKED;
                            miss_nxt  = 4'd0;
                        end
                    end else if (data != 8'h00) begin
                        pred_nxt  = lfsr_f(data);
                        match_nxt = 4'd0;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                LOCKED: begin
                    // free-running predictor: one corrupted byte costs exactly one error
                    pred_nxt = lfsr_f(pred);
                    if (data != pred) begin
                        mismatch = 1'b1;
                        miss_nxt = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;
`ifdef PRBS_CHK_RESYNC_EN
                        if (miss_nxt >= 4'(LOSS_CNT))
                            state_nxt = HUNT;
`endif
                    end else begin
                        miss_nxt = 4'd0;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            pred      <= 8'h00;
            match_cnt <= 4'd0;
            miss_cnt  <= 4'd0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            pred      <= pred_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            locked    <= (state_nxt == LOCKED);
            err_pulse <= mismatch;
            // clr wins over a same-edge increment
            if (clr)
                err_count <= '0;
            else if (mismatch && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker: behavioural stream model plus literal checkpoints.
module tb_prbs_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        locked, err_pulse, locked_s, err_pulse_s;
    logic [15:0] err_count;
    logic [3:0]  err_count_s;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data(data), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    // narrow counter copy so saturation is reachable quickly
    prbs_checker #(.ERR_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data(data), .clr(clr),
        .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s)
    );

    function automatic logic [7:0] nxt(input logic [7:0] x);
        int v, t;
        v = int'(x);
        t = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) & 255) | t);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // model: mode 0=searching, 1=confirming, 2=locked
    int mode = 0, mpred = 0, mrun = 0, mmiss = 0, c16 = 0, c4 = 0;
    bit e_lock = 0, e_pulse = 0, started = 0;

    always @(posedge clk) begin
        bit mis;
        int d;
        started = 1;
        mis = 0;
        d = int'(data);
        if (!rst_n) begin
            mode = 0; mpred = 0; mrun = 0; mmiss = 0; c16 = 0; c4 = 0;
            e_lock = 0; e_pulse = 0;
        end else begin
            if (valid) begin
                if (mode == 0) begin
                    if (d != 0) begin mpred = int'(nxt(8'(d))); mrun = 0; mode = 1; end
                end else if (mode == 1) begin
                    if (d == mpred) begin
                        mpred = int'(nxt(8'(d)));
                        mrun++;
                        if (mrun == LOCK_CNT) begin mode = 2; mmiss = 0; end
                    end else if (d != 0) begin
                        mpred = int'(nxt(8'(d))); mrun = 0;
                    end else begin
                        mode = 0;
                    end
                end else begin
                    mis = (d != mpred);
                    mpred = int'(nxt(8'(mpred)));
                    if (mis) mmiss = (mmiss < 15) ? mmiss + 1 : 15;
                    else mmiss = 0;
`ifdef PRBS_CHK_RESYNC_EN
                    if (mis && mmiss >= LOSS_CNT) mode = 0;
`endif
                end
            end
            e_pulse = mis;
            if (clr) begin c16 = 0; c4 = 0; end
            else if (mis) begin
                if (c16 < 65535) c16++;
                if (c4 < 15) c4++;
            end
            e_lock = (mode == 2);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("locked", int'(locked), int'(e_lock));
            chk("err_pulse", int'(err_pulse), int'(e_pulse));
            chk("err_count", int'(err_count), c16);
            chk("locked_s", int'(locked_s), int'(e_lock));
            chk("err_pulse_s", int'(err_pulse_s), int'(e_pulse));
            chk("err_count_s", int'(err_count_s), c4);
        end
    end

    logic [7:0] g;

    task automatic cyc(input bit v, input logic [7:0] d, input bit c);
        @(negedge clk);
        valid = v; data = d; clr = c;
    endtask

    task automatic good();
        g = nxt(g);
        cyc(1, g, 0);
    endtask

    task automatic bad(input logic [7:0] flip);
        g = nxt(g);
        cyc(1, g ^ flip, 0);
    endtask

    task automatic good_gap();
        repeat ($urandom_range(0, 3)) cyc(0, 8'h00, 0);
        good();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; valid = 0; clr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        g = 8'h01;
        do_reset();
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);

        // lock from seed 0x01: 01,02,04,08,11,23
        g = 8'h01;
        cyc(1, g, 0);
        good(); good(); good();
        cyc(0, 8'h00, 0);
        chk("prelock_locked", int'(locked), 0);
        good();
        chk("byte_0x11", int'(data), 8'h11);
        cyc(0, 8'h00, 0);
        chk("seed_locked", int'(locked), 1);
        chk("seed_err_count", int'(err_count), 0);
        good();

        // single-bit error
        bad(8'h01);
        cyc(0, 8'h00, 0);
        chk("single_pulse", int'(err_pulse), 1);
        chk("single_count", int'(err_count), 1);
        good();
        cyc(0, 8'h00, 0);
        chk("single_pulse_clear", int'(err_pulse), 0);
        good(); good(); good();
        cyc(0, 8'h00, 0);
        chk("single_still_locked", int'(locked), 1);
        chk("single_count_hold", int'(err_count), 1);

        // clr colliding with a mismatch
        repeat (4) begin bad(8'h40); good(); end
        cyc(0, 8'h00, 0);
        chk("count_five", int'(err_count), 5);
        g = nxt(g);
        cyc(1, g ^ 8'h02, 1);
        cyc(0, 8'h00, 0);
        chk("clr_count", int'(err_count), 0);
        chk("clr_pulse", int'(err_pulse), 1);

        // saturation of the narrow counter
        repeat (20) begin bad(8'h80); good(); end
        cyc(0, 8'h00, 0);
        chk("sat_narrow", int'(err_count_s), 15);
        chk("sat_wide", int'(err_count), 20);

        // three consecutive bad bytes
        cyc(0, 8'h00, 1);
        bad(8'h01); bad(8'h10); bad(8'hFF);
        cyc(0, 8'h00, 0);
        chk("burst_count", int'(err_count), 3);
`ifdef PRBS_CHK_RESYNC_EN
        chk("burst_unlocked", int'(locked), 0);
        g = 8'hC3;
        cyc(1, g, 0);
        good(); good(); good(); good();
        cyc(0, 8'h00, 0);
        chk("relock", int'(locked), 1);
`else
        chk("burst_locked", int'(locked), 1);
`endif

        // zero hold, then reseed mid-verify with bubbles
        do_reset();
        repeat (10) cyc(1, 8'h00, 0);
        cyc(0, 8'h00, 0);
        chk("zero_hunt", int'(locked), 0);
        g = 8'h5A;
        cyc(1, g, 0);
        good_gap(); good_gap();
        g = nxt(g) ^ 8'h10;
        cyc(1, g, 0);
        good_gap(); good_gap(); good_gap();
        cyc(0, 8'h00, 0);
        chk("reseed_not_yet", int'(locked), 0);
        good_gap();
        cyc(0, 8'h00, 0);
        chk("reseed_locked", int'(locked), 1);
        repeat (6) good_gap();
        cyc(0, 8'h00, 0);
        chk("gap_no_errors", int'(err_count), 0);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                do_reset();
            end else if (r < 250) begin
                cyc(0, 8'($urandom), ($urandom_range(0, 49) == 0));
            end else begin
                bit c;
                c = ($urandom_range(0, 49) == 0);
                r = int'($urandom_range(0, 99));
                if (r < 85) begin
                    g = nxt(g); cyc(1, g, c);
                end else if (r < 92) begin
                    g = nxt(g); cyc(1, 8'($urandom), c);
                end else if (r < 96) begin
                    g = 8'($urandom_range(1, 255)); cyc(1, g, c);
                end else begin
                    cyc(1, 8'h00, c);
                end
            end
        end

        repeat (3) cyc(0, 8'h00, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the 8-bit LFSR random generator.
- Consumes the generator's byte stream and self-synchronises to it from any nonzero sample.
- Declares lock after a run of correct predictions, then flags and counts every byte that departs from the LFSR sequence.
- Used as the on-chip link/self-test checker for the random-number path.

Parameters:
- LOCK_CNT, 4, consecutive correct predictions needed in VERIFY to enter LOCKED (legal range 1..15).
- LOSS_CNT, 3, consecutive mismatches in LOCKED that force resync (legal range 1..15; used only with the optional feature).
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- valid  input  1  a new data byte is present this cycle.
- data  input  8  received random byte.
- clr  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle flag: the previous valid byte mismatched while LOCKED.
- err_count  output  ERR_W  saturating mismatch count.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Sequence definition: f(x) = {x[6:0], x[7]^x[5]^x[4]^x[3]}, i.e. x^8+x^6+x^5+x^4+1 Fibonacci form. This matches the generator exactly.
- Reset (rst_n=0 at an edge):
  - state=HUNT; pred=0; match_cnt=0; miss_cnt=0.
  - locked=0; err_pulse=0; err_count=0.
  - A reset mid-lock discards all state.
- Cycles with valid=0 change no state. err_pulse returns to 0 on those cycles.
- HUNT:
  - valid with data!=0: pred<=f(data); match_cnt<=0; go to VERIFY.
  - data==0 is the LFSR lockup value. It is ignored and the block stays in HUNT.
- VERIFY:
  - valid and data==pred: pred<=f(data); match_cnt++. If match_cnt==LOCK_CNT-1, go to LOCKED and clear miss_cnt.
  - valid, data!=pred, data!=0: reseed with pred<=f(data); match_cnt<=0; stay in VERIFY.
  - valid and data==0 (mismatch): go to HUNT.
  - No errors are counted outside LOCKED.
- LOCKED:
  - Every valid byte: pred<=f(pred). The predictor free-runs, so a single corrupted byte yields exactly one error.
  - Match: miss_cnt<=0.
  - Mismatch: err_pulse=1 in the following cycle; err_count increments, saturating at 2^ERR_W-1 with no wrap; miss_cnt increments, saturating at 15.
- Output timing: all outputs are registered.
  - locked rises in the cycle after the edge that samples the LOCK_CNT-th match.
  - err_pulse is high for exactly one cycle per mismatching valid byte. Back-to-back mismatches keep it high.
- clr priority: clr=1 forces err_count to 0 at that edge, overriding a simultaneous increment. err_pulse still fires for that mismatch.
- clr does not affect state, pred or locked.

Optional Feature:
- Macro PRBS_CHK_RESYNC_EN.
- Defined: in LOCKED, when miss_cnt reaches LOSS_CNT (including the current mismatch), go to HUNT at that edge. locked falls the next cycle; err_count is retained.
- Undefined: LOCKED is left only by reset. miss_cnt is still maintained but unused, and LOSS_CNT is ignored.

Test Plan:
- Lock from seed 0x01: reset, then valid bytes 0x01,0x02,0x04,0x08,0x11,0x23 -> locked=1 the cycle after 0x11 is sampled; err_count=0; err_pulse never asserts.
- Single-bit error: once locked, feed the sequence with one byte XOR 0x01 -> exactly one err_pulse cycle; err_count=1; following bytes match; locked stays 1.
- Zero and reseed handling: hold data=0x00 with valid for 10 cycles -> stays in HUNT, locked=0. Then inject a wrong byte mid-VERIFY -> reseed; lock after 4 further matches.
- valid gaps: insert valid=0 bubbles between sequence bytes -> same lock timing in valid-byte count; no errors.
- clr collision: with err_count=5, assert clr on the same edge as a mismatch -> err_count=0 and err_pulse=1. Saturation: force 65536 errors -> err_count holds at 0xFFFF.
- With PRBS_CHK_RESYNC_EN: 3 consecutive bad bytes -> locked falls after the third and the checker relocks on a fresh sequence. Without the macro: locked stays 1 and err_count=3.
